// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer stepped by rising edges of the divided clock clk_N.
// Load/start/pause control, done pulse at 00:00, load-error pulse on bad loads.
module bcd_countdown_timer #(
   parameter logic [7:0] MIN_MAX = 8'h99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_N,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       load_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic       clk_N_d;
   logic       tick;
   logic       load_ok;
   logic       is_zero;
   logic       dec_zero;
   logic       b0;
   logic       b1;
   logic       b2;
   logic [7:0] dmin;
   logic [7:0] dsec;
   logic [7:0] min_nx;
   logic [7:0] sec_nx;
   logic       done_nx;
   logic       err_nx;

   assign tick = clk_N & ~clk_N_d;

   assign load_ok = (load_min[7:4] <= 4'd9) &
                    (load_min[3:0] <= 4'd9) &
                    (load_sec[7:4] <= 4'd5) &
                    (load_sec[3:0] <= 4'd9) &
                    (load_min <= MIN_MAX);

   assign is_zero = (min_bcd == 8'h00) & (sec_bcd == 8'h00);

   // Borrow chain across the four BCD digits
   assign b0 = (sec_bcd[3:0] == 4'd0);
   assign b1 = b0 & (sec_bcd[7:4] == 4'd0);
   assign b2 = b1 & (min_bcd[3:0] == 4'd0);

   always_comb begin
      dsec = sec_bcd;
      dmin = min_bcd;
      dsec[3:0] = b0 ? 4'd9 : sec_bcd[3:0] - 4'd1;
      if (b0) dsec[7:4] = b1 ? 4'd5 : sec_bcd[7:4] - 4'd1;
      if (b1) dmin[3:0] = b2 ? 4'd9 : min_bcd[3:0] - 4'd1;
      if (b2) dmin[7:4] = min_bcd[7:4] - 4'd1;
   end

   assign dec_zero = (dmin == 8'h00) & (dsec == 8'h00);

   always_comb begin
      state_nx = state;
      min_nx   = min_bcd;
      sec_nx   = sec_bcd;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (load) begin
         if (load_ok) begin
            min_nx   = load_min;
            sec_nx   = load_sec;
            state_nx = IDLE;
         end else begin
            err_nx = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_zero) begin
                     state_nx = DONE;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = RUN;
                  end
               end
            end
            RUN: begin
               // start outranks pause and tick, so it just holds the count
               if (!start) begin
                  if (pause) begin
                     state_nx = PAUSE;
                  end else if (tick) begin
                     min_nx = dmin;
                     sec_nx = dsec;
                     if (dec_zero) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                     end
                  end
               end
            end
            PAUSE: begin
               if (start) state_nx = RUN;
            end
            DONE: begin
               state_nx = DONE;
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
         running  <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
         clk_N_d  <= 1'b0;
      end else begin
         state    <= state_nx;
         min_bcd  <= min_nx;
         sec_bcd  <= sec_nx;
         running  <= (state_nx == RUN);
         done     <= done_nx;
         load_err <= err_nx;
         clk_N_d  <= clk_N;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed sequences, a load table and
// randomized control checked every cycle against a seconds-count model.
module tb_bcd_countdown_timer;

   localparam logic [7:0] MIN_MAX = 8'h99;
   localparam int N = 10;
   localparam int M_IDLE = 0;
   localparam int M_RUN = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       clk_N = 1'b0;
   logic       load = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_sec = 8'h00;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       done;
   logic       load_err;

   int vectors = 0;
   int miscompares = 0;
   int dcnt = 0;
   int tsec = 0;
   int mode = M_IDLE;
   logic m_nd = 1'b0;
   logic m_done = 1'b0;
   logic m_err = 1'b0;

   typedef struct {
      logic [7:0] lmin;
      logic [7:0] lsec;
      logic       err;
      logic [7:0] emin;
      logic [7:0] esec;
   } ld_vec_t;

   ld_vec_t tbl [8];

   bcd_countdown_timer #(.MIN_MAX(MIN_MAX)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clk_N(clk_N),
      .load(load),
      .load_min(load_min),
      .load_sec(load_sec),
      .start(start),
      .pause(pause),
      .min_bcd(min_bcd),
      .sec_bcd(sec_bcd),
      .running(running),
      .done(done),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   // Divide-by-N source: low for N/2 cycles, high for N/2 cycles
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt  <= 0;
         clk_N <= 1'b0;
      end else begin
         dcnt  <= (dcnt + 1) % N;
         clk_N <= (((dcnt + 1) % N) >= N / 2);
      end
   end

   function automatic int bcd2i(input logic [7:0] b);
      return 10 * int'(b[7:4]) + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] i2bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic ld_ok(input logic [7:0] m, input logic [7:0] s);
      return int'(m[7:4]) <= 9 && int'(m[3:0]) <= 9 &&
             int'(s[7:4]) <= 5 && int'(s[3:0]) <= 9 &&
             bcd2i(m) <= bcd2i(MIN_MAX);
   endfunction

   function automatic logic [31:0] exp_o(input logic [7:0] m, input logic [7:0] s,
                                         input logic r, input logic d, input logic e);
      return {8'h00, m, s, 5'b0, r, d, e};
   endfunction

   function automatic logic [31:0] outs();
      return {8'h00, min_bcd, sec_bcd, 5'b0, running, done, load_err};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: the time left as a plain number of seconds
   always @(posedge clk or negedge rst_n) begin : model
      int t;
      int md;
      logic d;
      logic e;
      if (!rst_n) begin
         tsec   <= 0;
         mode   <= M_IDLE;
         m_nd   <= 1'b0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
      end else begin
         t = tsec;
         md = mode;
         d = 1'b0;
         e = 1'b0;
         if (load) begin
            if (ld_ok(load_min, load_sec)) begin
               t = bcd2i(load_min) * 60 + bcd2i(load_sec);
               md = M_IDLE;
            end else begin
               e = 1'b1;
            end
         end else if (md == M_IDLE && start) begin
            if (t == 0) begin
               md = M_DONE;
               d = 1'b1;
            end else begin
               md = M_RUN;
            end
         end else if (md == M_PAUSE && start) begin
            md = M_RUN;
         end else if (md == M_RUN && !start) begin
            if (pause) begin
               md = M_PAUSE;
            end else if (clk_N && !m_nd) begin
               t = t - 1;
               if (t == 0) begin
                  md = M_DONE;
                  d = 1'b1;
               end
            end
         end
         tsec   <= t;
         mode   <= md;
         m_nd   <= clk_N;
         m_done <= d;
         m_err  <= e;
      end
   end

   always @(negedge clk) begin
      chk("model", outs(),
          exp_o(i2bcd(tsec / 60), i2bcd(tsec % 60), mode == M_RUN, m_done, m_err));
   end

   task automatic do_load(input logic [7:0] m, input logic [7:0] s);
      load_min = m;
      load_sec = s;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1;
      @(negedge clk);
      pause = 1'b0;
   endtask

   task automatic wait_chg(input string nm, output int waited);
      logic [7:0] prev;
      prev = sec_bcd;
      waited = 0;
      while (waited < 40) begin
         @(negedge clk);
         waited++;
         if (sec_bcd !== prev) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL %s: sec_bcd stuck at %h for 40 clk, change required", nm, prev);
   endtask

   initial begin
      int w;
      tbl[0] = '{8'h00, 8'h30, 1'b0, 8'h00, 8'h30};
      tbl[1] = '{8'h00, 8'h60, 1'b1, 8'h00, 8'h30};
      tbl[2] = '{8'h1A, 8'h00, 1'b1, 8'h00, 8'h30};
      tbl[3] = '{8'h99, 8'h59, 1'b0, 8'h99, 8'h59};
      tbl[4] = '{8'hA0, 8'h00, 1'b1, 8'h99, 8'h59};
      tbl[5] = '{8'h12, 8'h5A, 1'b1, 8'h99, 8'h59};
      tbl[6] = '{8'h10, 8'h00, 1'b0, 8'h10, 8'h00};
      tbl[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset", outs(), 32'h0);
      repeat (5) @(negedge clk);
      chk("idle_hold", outs(), 32'h0);

      do_load(8'h00, 8'h03);
      do_start();
      wait_chg("c02", w);
      chk("c02", outs(), exp_o(8'h00, 8'h02, 1'b1, 1'b0, 1'b0));
      wait_chg("c01", w);
      chk("c01_gap", w, 10);
      chk("c01", outs(), exp_o(8'h00, 8'h01, 1'b1, 1'b0, 1'b0));
      wait_chg("c00", w);
      chk("c00_gap", w, 10);
      chk("c00_done", outs(), exp_o(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      chk("c00_after", outs(), 32'h0);

      do_load(8'h01, 8'h00);
      do_start();
      wait_chg("b0100", w);
      chk("b0100", outs(), exp_o(8'h00, 8'h59, 1'b1, 1'b0, 1'b0));
      do_load(8'h10, 8'h00);
      chk("abort_ld", outs(), exp_o(8'h10, 8'h00, 1'b0, 1'b0, 1'b0));
      do_start();
      wait_chg("b1000", w);
      chk("b1000", outs(), exp_o(8'h09, 8'h59, 1'b1, 1'b0, 1'b0));

      do_load(8'h00, 8'h05);
      do_start();
      wait_chg("p04", w);
      wait_chg("p03", w);
      do_pause();
      repeat (30) @(negedge clk);
      chk("p_hold", outs(), exp_o(8'h00, 8'h03, 1'b0, 1'b0, 1'b0));
      do_start();
      wait_chg("p02", w);
      chk("p02", outs(), exp_o(8'h00, 8'h02, 1'b1, 1'b0, 1'b0));
      repeat (9) @(negedge clk);
      do_pause();
      chk("pause_tick", outs(), exp_o(8'h00, 8'h02, 1'b0, 1'b0, 1'b0));
      repeat (12) @(negedge clk);
      chk("pause_ign", outs(), exp_o(8'h00, 8'h02, 1'b0, 1'b0, 1'b0));
      do_start();
      wait_chg("p01", w);
      chk("p01", outs(), exp_o(8'h00, 8'h01, 1'b1, 1'b0, 1'b0));
      repeat (9) @(negedge clk);
      do_start();
      chk("start_tick", outs(), exp_o(8'h00, 8'h01, 1'b1, 1'b0, 1'b0));
      wait_chg("p00", w);
      chk("p00_gap", w, 10);
      chk("p00", outs(), exp_o(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));

      for (int i = 0; i < 8; i++) begin
         do_load(tbl[i].lmin, tbl[i].lsec);
         chk($sformatf("ld%0d", i), outs(),
             exp_o(tbl[i].emin, tbl[i].esec, 1'b0, 1'b0, tbl[i].err));
         @(negedge clk);
         chk($sformatf("ld%0d_pulse", i), {31'b0, load_err}, 32'h0);
      end

      do_start();
      chk("zero_start", outs(), exp_o(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      chk("zero_after", outs(), 32'h0);
      do_start();
      chk("done_ign_start", outs(), 32'h0);
      do_pause();
      chk("done_ign_pause", outs(), 32'h0);

      do_load(8'h00, 8'h43);
      do_start();
      wait_chg("r42", w);
      chk("r42", outs(), exp_o(8'h00, 8'h42, 1'b1, 1'b0, 1'b0));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", outs(), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst", outs(), 32'h0);
      do_start();
      chk("post_rst_done", outs(), exp_o(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));

      for (int i = 0; i < 4000; i++) begin
         load  = ($urandom_range(0, 39) == 0);
         start = ($urandom_range(0, 11) == 0);
         pause = ($urandom_range(0, 15) == 0);
         if (load) begin
            if ($urandom_range(0, 9) == 0) load_min = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) load_min = 8'h01;
            else load_min = 8'h00;
            load_sec = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
         end
         @(negedge clk);
      end
      load = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
